// File: rtl/leg_pkg.sv
// Shared defaults for the instruction prefetch path.
package leg_pkg;

    localparam int ADDR_WIDTH = 12;
    localparam int DATA_WIDTH = 8;
    localparam int INST_BYTES = 2;
    localparam int INST_WIDTH = INST_BYTES * DATA_WIDTH;
    localparam int FIFO_DEPTH = 4;

    // Width of a counter spanning 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with combinational head read, flush, and
// simultaneous push/pop at any occupancy (including full).
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PW-1:0]    wr_ptr_reg;
    logic [PW-1:0]    rd_ptr_reg;
    logic [PW:0]      count_reg;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == (PW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A push into a full queue is legal only because the head leaves this same edge.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem_reg[rd_ptr_reg];

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            count_reg <= count_reg + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, do_pop};
        end
    end

    always_ff @(posedge i_clk) begin
        if (do_push && !flush) begin
            mem_reg[wr_ptr_reg] <= wdata;
        end
    end

endmodule

// File: rtl/prefetch_unit.sv
// Sequential instruction prefetcher: reads one memory word per cycle, assembles
// INST_BYTES words per instruction and queues {pc, instruction} for the consumer.
module prefetch_unit #(
    parameter int                        ADDR_WIDTH = leg_pkg::ADDR_WIDTH,
    parameter int                        DATA_WIDTH = leg_pkg::DATA_WIDTH,
    parameter int                        INST_BYTES = leg_pkg::INST_BYTES,
    parameter int                        FIFO_DEPTH = leg_pkg::FIFO_DEPTH,
    parameter logic [ADDR_WIDTH-1:0]     RESET_PC   = '0
) (
    input  logic                             i_clk,
    input  logic                             i_rst_n,
    input  logic [DATA_WIDTH-1:0]            i_mem_data,
    output logic [ADDR_WIDTH-1:0]            o_mem_addr,
    output logic                             o_mem_read,
    output logic                             o_mem_write,
    input  logic                             i_redirect,
    input  logic [ADDR_WIDTH-1:0]            i_redirect_pc,
    output logic                             o_inst_valid,
    input  logic                             i_inst_ready,
    output logic [INST_BYTES*DATA_WIDTH-1:0] o_inst,
    output logic [ADDR_WIDTH-1:0]            o_inst_pc
);

    import leg_pkg::*;

    localparam int              CW        = cnt_width(INST_BYTES);
    localparam int              IW        = INST_BYTES * DATA_WIDTH;
    localparam logic [CW-1:0]   LAST_WORD = CW'(INST_BYTES - 1);

    logic [ADDR_WIDTH-1:0]    fp_reg;
    logic [ADDR_WIDTH-1:0]    start_pc_reg;
    logic [ADDR_WIDTH-1:0]    push_pc;
    logic [CW-1:0]            cnt_reg;
    logic [IW-1:0]            asm_reg;
    logic [IW-1:0]            asm_next;
    logic                     at_last;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic                     pop;
    logic                     push;
    logic [ADDR_WIDTH+IW-1:0] fifo_rdata;

    assign at_last     = (cnt_reg == LAST_WORD);
    assign pop         = !fifo_empty && i_inst_ready && !i_redirect;
    assign o_mem_read  = !i_redirect && !(at_last && fifo_full && !pop);
    assign push        = o_mem_read && at_last;
    assign o_mem_addr  = fp_reg;
    assign o_mem_write = 1'b0;
    // A single-word instruction starts at the word being consumed right now.
    assign push_pc     = (cnt_reg == '0) ? fp_reg : start_pc_reg;

    // Word k lands in its own slot, first word in the MSBs. When the last word
    // is consumed asm_next already holds the complete instruction.
    for (genvar gi = 0; gi < INST_BYTES; gi++) begin : g_slot
        assign asm_next[(INST_BYTES-gi)*DATA_WIDTH-1 -: DATA_WIDTH] =
            (o_mem_read && cnt_reg == CW'(gi)) ? i_mem_data
                                               : asm_reg[(INST_BYTES-gi)*DATA_WIDTH-1 -: DATA_WIDTH];
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            fp_reg       <= RESET_PC;
            cnt_reg      <= '0;
            asm_reg      <= '0;
            start_pc_reg <= '0;
        end else if (i_redirect) begin
            fp_reg  <= i_redirect_pc;
            cnt_reg <= '0;
            asm_reg <= '0;
        end else if (o_mem_read) begin
            fp_reg  <= fp_reg + ADDR_WIDTH'(1);
            cnt_reg <= at_last ? '0 : cnt_reg + CW'(1);
            asm_reg <= asm_next;
            if (cnt_reg == '0) begin
                start_pc_reg <= fp_reg;
            end
        end
    end

    sync_fifo #(
        .WIDTH (ADDR_WIDTH + IW),
        .DEPTH (FIFO_DEPTH)
    ) u_queue (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .push    (push),
        .pop     (pop),
        .flush   (i_redirect),
        .wdata   ({push_pc, asm_next}),
        .rdata   (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign o_inst_valid = !fifo_empty;
    assign o_inst       = o_inst_valid ? fifo_rdata[IW-1:0] : '0;
    assign o_inst_pc    = o_inst_valid ? fifo_rdata[ADDR_WIDTH+IW-1:IW] : '0;

endmodule

// File: tb/tb_prefetch_unit.sv
// Scoreboard bench for prefetch_unit: directed scenarios followed by random
// reset/redirect/ready traffic against a queue-based reference model.
module tb_prefetch_unit;

    localparam int             AW    = 12;
    localparam int             DW    = 8;
    localparam int             IB    = 2;
    localparam int             IW    = IB * DW;
    localparam int             DEPTH = 4;
    localparam logic [AW-1:0]  RPC   = 12'h000;

    logic          i_clk = 1'b0;
    logic          i_rst_n = 1'b0;
    logic          i_redirect = 1'b0;
    logic          i_inst_ready = 1'b0;
    logic [AW-1:0] i_redirect_pc = '0;
    logic [DW-1:0] i_mem_data;
    logic [AW-1:0] o_mem_addr;
    logic [AW-1:0] o_inst_pc;
    logic          o_mem_read;
    logic          o_mem_write;
    logic          o_inst_valid;
    logic [IW-1:0] o_inst;

    int checks = 0;
    int errors = 0;
    bit mem_mode = 1'b0;
    bit mon_en = 1'b0;

    // Reference model: fetch address, words gathered so far, queued instructions.
    logic [AW-1:0]    m_fp;
    logic [AW-1:0]    m_start;
    logic [DW-1:0]    m_words[$];
    logic [AW+IW-1:0] exp_q[$];

    always #5 i_clk = ~i_clk;

    function automatic logic [DW-1:0] mem_byte(input logic [AW-1:0] a, input bit mode);
        return mode ? (a[7:0] ^ {a[11:8], a[3:0]} ^ 8'h5A) : a[7:0];
    endfunction

    assign i_mem_data = mem_byte(o_mem_addr, mem_mode);

    prefetch_unit #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .INST_BYTES (IB),
        .FIFO_DEPTH (DEPTH),
        .RESET_PC   (RPC)
    ) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_mem_data    (i_mem_data),
        .o_mem_addr    (o_mem_addr),
        .o_mem_read    (o_mem_read),
        .o_mem_write   (o_mem_write),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .o_inst_valid  (o_inst_valid),
        .i_inst_ready  (i_inst_ready),
        .o_inst        (o_inst),
        .o_inst_pc     (o_inst_pc)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs on the falling edge, advance the model at the rising edge.
    task automatic step(input bit rst_n, input bit redir, input logic [AW-1:0] rpc, input bit rdy);
        logic [IW-1:0] ins;
        @(negedge i_clk);
        i_rst_n       = rst_n;
        i_redirect    = redir;
        i_redirect_pc = rpc;
        i_inst_ready  = rdy;
        @(posedge i_clk);
        if (!rst_n) begin
            m_fp = RPC;
            m_words.delete();
            exp_q.delete();
        end else if (redir) begin
            m_fp = rpc;
            m_words.delete();
            exp_q.delete();
        end else if (!(m_words.size() == IB-1 && exp_q.size() == DEPTH)) begin
            // The monitor has already removed a popped head, so a full queue here means no pop.
            if (m_words.size() == 0) m_start = m_fp;
            m_words.push_back(mem_byte(m_fp, mem_mode));
            m_fp = m_fp + 1'b1;
            if (m_words.size() == IB) begin
                ins = '0;
                foreach (m_words[k]) ins = (ins << DW) | IW'(m_words[k]);
                exp_q.push_back({m_start, ins});
                m_words.delete();
            end
        end
    endtask

    // Monitor: compares every cycle and retires the expected head on each handshake.
    initial begin : monitor
        bit               pop_now;
        bit               exp_read;
        logic [AW+IW-1:0] head;
        forever begin
            @(negedge i_clk);
            #2;
            if (mon_en) begin
                pop_now  = (exp_q.size() != 0) && i_inst_ready && !i_redirect;
                exp_read = !i_redirect && !(m_words.size() == IB-1 && exp_q.size() == DEPTH && !pop_now);
                chk("mem_addr", o_mem_addr, m_fp);
                chk("mem_read", o_mem_read, exp_read);
                chk("mem_write", o_mem_write, 1'b0);
                chk("inst_valid", o_inst_valid, exp_q.size() != 0);
                if (exp_q.size() == 0) begin
                    chk("idle_inst", o_inst, '0);
                    chk("idle_pc", o_inst_pc, '0);
                end else begin
                    head = exp_q[0];
                    chk("head_pc", o_inst_pc, head[AW+IW-1:IW]);
                    chk("head_inst", o_inst, head[IW-1:0]);
                    if (pop_now && i_rst_n) begin
                        void'(exp_q.pop_front());
                        $display("pop pc=%03h inst=%04h t=%0t", o_inst_pc, o_inst, $time);
                    end
                end
            end
        end
    end

    initial begin : stimulus
        bit            r_rst;
        bit            r_redir;
        bit            r_rdy;
        logic [AW-1:0] r_pc;
        int            thresh;

        step(0, 0, '0, 0);
        step(0, 0, '0, 0);
        mon_en = 1'b1;
        #1;
        chk("rst_valid", o_inst_valid, 1'b0);
        chk("rst_addr", o_mem_addr, RPC);
        chk("rst_inst", o_inst, '0);
        chk("rst_pc", o_inst_pc, '0);

        // Memory byte = address; first instruction two cycles after release.
        step(1, 0, '0, 1); #1 chk("lat1_valid", o_inst_valid, 1'b0);
        step(1, 0, '0, 1); #1;
        chk("lat2_valid", o_inst_valid, 1'b1);
        chk("lat2_inst", o_inst, 16'h0001);
        chk("lat2_pc", o_inst_pc, 12'h000);
        step(1, 0, '0, 1);
        step(1, 0, '0, 1); #1;
        chk("seq_inst", o_inst, 16'h0203);
        chk("seq_pc", o_inst_pc, 12'h002);

        // Consumer stalled: words 0..7 fill the queue, word 8 is latched, fetch holds at 0x009.
        step(0, 0, '0, 0);
        repeat (20) step(1, 0, '0, 0);
        #1;
        chk("stall_read", o_mem_read, 1'b0);
        chk("stall_addr", o_mem_addr, 12'h009);
        for (int k = 0; k < 4; k++) begin
            chk("drain_valid", o_inst_valid, 1'b1);
            chk("drain_pc", o_inst_pc, 32'(k * 2));
            step(1, 0, '0, 1);
            #1;
        end

        // Redirect mid-instruction with three queued.
        step(0, 0, '0, 0);
        repeat (7) step(1, 0, '0, 0);
        step(1, 1, 12'h100, 1); #1;
        chk("redir_valid0", o_inst_valid, 1'b0);
        chk("redir_addr", o_mem_addr, 12'h100);
        step(1, 0, '0, 1); #1 chk("redir_valid1", o_inst_valid, 1'b0);
        step(1, 0, '0, 1); #1;
        chk("redir_valid2", o_inst_valid, 1'b1);
        chk("redir_pc", o_inst_pc, 12'h100);
        chk("redir_inst", o_inst, 16'h0001);

        // Address wrap inside an instruction.
        step(1, 1, 12'hFFF, 1);
        step(1, 0, '0, 1);
        step(1, 0, '0, 1); #1;
        chk("wrap_pc", o_inst_pc, 12'hFFF);
        chk("wrap_inst", o_inst, 16'hFF00);
        step(1, 0, '0, 1);
        step(1, 0, '0, 1); #1;
        chk("wrap_next_pc", o_inst_pc, 12'h001);
        chk("wrap_next_inst", o_inst, 16'h0102);

        // Full queue with push and pop on the same edge.
        step(0, 0, '0, 0);
        repeat (20) step(1, 0, '0, 0);
        step(1, 0, '0, 1); #1;
        chk("pp_pc", o_inst_pc, 12'h002);
        step(1, 0, '0, 0);
        step(1, 0, '0, 0);
        for (int k = 0; k < 5; k++) begin
            #1 chk("pp_order", o_inst_pc, 32'(2 + k * 2));
            step(1, 0, '0, 1);
        end

        // Reset wins over redirect and a pending handshake.
        step(0, 0, '0, 0);
        repeat (5) step(1, 0, '0, 0);
        step(0, 1, 12'h300, 1); #1;
        chk("rst_ovr_valid", o_inst_valid, 1'b0);
        chk("rst_ovr_addr", o_mem_addr, RPC);

        // Random traffic with a scrambled memory image.
        mem_mode = 1'b1;
        step(0, 0, '0, 0);
        thresh = 50;
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) thresh = $urandom_range(0, 2) * 40 + 10;
            r_rst   = ($urandom_range(0, 149) != 0);
            r_redir = ($urandom_range(0, 24) == 0);
            r_pc    = ($urandom_range(0, 3) == 0) ? AW'(12'hFFE + $urandom_range(0, 1)) : AW'($urandom);
            r_rdy   = ($urandom_range(0, 99) < thresh);
            step(r_rst, r_redir, r_pc, r_rdy);
        end

        @(negedge i_clk);
        #3;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
